// File: rtl/ysyx_25030081_mem_pkg.sv
// Shared memory-port definitions: responder FSM encoding, lane count and the
// default base address the core also uses as its PC reset value.
package ysyx_25030081_mem_pkg;

    localparam int MEM_DATA_WIDTH = 32;
    localparam int MEM_BYTE_LANES = MEM_DATA_WIDTH / 8;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/ysyx_25030081_sram_array.sv
// Single-port word array with byte-masked write and registered read.
// A read that coincides with a write to the same word returns the old data.
import ysyx_25030081_mem_pkg::*;

module ysyx_25030081_sram_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                      clk,
    input  logic                      en_i,
    input  logic                      we_i,
    input  logic [DEPTH_LOG2-1:0]     addr_i,
    input  logic [MEM_DATA_WIDTH-1:0] wdata_i,
    input  logic [MEM_BYTE_LANES-1:0] wmask_i,
    output logic [MEM_DATA_WIDTH-1:0] rdata_o
);

    logic [MEM_DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];
    logic [MEM_DATA_WIDTH-1:0] rdata_q;

    // Storage and read register: no reset, contents survive rst.
    always_ff @(posedge clk) begin
        if (en_i) begin
            rdata_q <= mem_q[addr_i];
            if (we_i) begin
                for (int i = 0; i < MEM_BYTE_LANES; i++) begin
                    if (wmask_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ysyx_25030081_imem_resp.sv
// Memory-side responder: one request at a time, fixed access latency,
// access performed on the edge that enters RESP, response held until taken.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the sender keeps its payload stable while valid is high and
// ready is low, and the receiver samples payload only on the transfer edge.
import ysyx_25030081_mem_pkg::*;

module ysyx_25030081_imem_resp #(
    parameter int                   ADDR_WIDTH = 32,
    parameter int                   DATA_WIDTH = 32,
    parameter int                   DEPTH_LOG2 = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int                   LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_wen,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [1:0]              dbg_state
);

    mem_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    wen_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wmask_q;

    logic [ADDR_WIDTH-1:0] offset;
    logic                  fault;
    logic                  do_access;
    logic [DATA_WIDTH-1:0] sram_rdata;

    // Unsigned offset from the base: addresses below BASE wrap high and fault.
    // BASE is word aligned, so the offset's low bits equal the address's.
    assign offset    = addr_q - BASE_ADDR;
    assign fault     = (offset[1:0] != 2'b00) ||
                       (offset[ADDR_WIDTH-1:DEPTH_LOG2+2] != '0);
    assign do_access = (state_q == ST_WAIT) && (cnt_q == 4'd0);

    // Next-state, counter and fault-flag logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    err_d   = fault;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                err_d   = 1'b0;
            end
        endcase
    end

    // FSM, counter and fault flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Request capture: only on the accept edge, later changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (state_q == ST_IDLE && req_valid) begin
            addr_q  <= req_addr;
            wen_q   <= req_wen;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
        end
    end

    ysyx_25030081_sram_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk    (clk),
        .en_i   (do_access && !fault && !rst),
        .we_i   (wen_q),
        .addr_i (offset[DEPTH_LOG2+1:2]),
        .wdata_i(wdata_q),
        .wmask_i(wmask_q),
        .rdata_o(sram_rdata)
    );

    // The array's read register only moves on an access, so data is stable in RESP.
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = err_q;
    assign rsp_rdata = (rsp_valid && !err_q && !wen_q) ? sram_rdata : '0;
    assign dbg_state = state_q;

endmodule

// File: doc/ysyx_25030081_imem_resp.md
Name: ysyx_25030081_imem_resp

Overview:
- Memory-side responder for the core's fetch/load-store port: accepts one request at a time over a valid/ready request channel and returns one response over a valid/ready response channel.
- Backed by an internal word-addressed array with a fixed, parameterised access latency.
- Replaces the ideal combinational `inst` feed so the core's fetch path can be built and verified against a realistic multi-cycle memory.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, word width (fixed at 32; wmask is DATA_WIDTH/8 bits)
DEPTH_LOG2, 10, log2 of array depth in words (default 1024 words = 4 KiB)
BASE_ADDR, 32'h8000_0000, byte address of word 0
LATENCY, 2, cycles from the request-accept edge to rsp_valid high; legal range 1..15

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_addr  in  ADDR_WIDTH  byte address
req_wen  in  1  1 = write, 0 = read
req_wdata  in  DATA_WIDTH  write data
req_wmask  in  DATA_WIDTH/8  byte enables for writes; ignored on reads
rsp_valid  out  1  response present
rsp_ready  in  1  requester takes the response
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
rsp_err  out  1  access fault (misaligned or out of range)

Behaviour:
- Reset: synchronous, active-high, on clk. Results after reset:
  - state = IDLE, req_ready = 1.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - Latency counter = 0.
  - Array contents are NOT reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: latch addr, wen, wdata and wmask. Load counter with LATENCY-1. Go to WAIT.
- WAIT:
  - req_ready = 0.
  - Counter decrements each cycle.
  - When counter == 0 at a clock edge: perform the access and go to RESP.
  - Net effect: rsp_valid rises exactly LATENCY cycles after the accept edge.
- Access, committed on the edge that enters RESP:
  - Fault checks:
    - Misaligned: latched addr[1:0] != 0.
    - Out of range: (addr - BASE_ADDR) >= 4 << DEPTH_LOG2, computed as unsigned ADDR_WIDTH subtraction, so addresses below BASE wrap and fault.
  - On a fault: rsp_err = 1, rsp_rdata = 0, and the array is untouched.
  - Read with no fault: rsp_rdata = array[(addr - BASE) >> 2].
  - Write with no fault: for each i, byte i is written iff wmask[i]. rsp_rdata = 0.
  - Write with wmask == 0: legal no-op, response still returned with err = 0.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until the handshake.
  - req_ready = 0.
  - On rsp_ready: next state IDLE, and rsp_valid, rsp_rdata and rsp_err clear to 0 on that edge.
  - No request is accepted on the response-handshake cycle. Minimum turnaround is LATENCY+1 cycles per transaction.
- Request signals are sampled only on the accept edge; changes while busy are ignored.
- rsp_ready asserted while rsp_valid = 0 has no effect.
- Reset during WAIT: the pending access is dropped and no array write occurs.
- Reset during RESP: the response is discarded and no handshake is needed.

Decomposition:
- Shared package ysyx_25030081_mem_pkg:
  - State encoding IDLE/WAIT/RESP (2 bits).
  - Byte-lane count DATA_WIDTH/8.
  - Default BASE_ADDR constant, shared with the core's PC reset value.
- One sub-module, ysyx_25030081_sram_array:
  - Single-port array of 2^DEPTH_LOG2 x 32.
  - Synchronous byte-masked write and registered read on the same edge. Read-during-write returns the old data.
  - No reset on storage.

Test Plan:
1. Reset: hold rst 2 cycles with req_valid=1 -> req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0 on the first cycle after rst drops.
2. Write then read, LATENCY=2: write addr 0x8000_0010, wdata 0xDEADBEEF, wmask 4'hF. rsp_valid high 2 cycles after accept, err=0, rdata=0. Then read the same address -> rdata 0xDEADBEEF, err=0, 2 cycles after accept.
3. Byte mask: write 0x1122_3344 with wmask 4'b0101 over 0xDEADBEEF at the same address, then read -> rdata 0xDE22BE44.
4. Backpressure: issue a read, hold rsp_ready=0 for 5 cycles -> rsp_valid and rdata stable throughout, req_ready=0. Raise rsp_ready -> next cycle rsp_valid=0 and req_ready=1.
5. Faults:
   - Read 0x8000_0002 -> err=1, rdata=0.
   - Write 0x8000_1000 (past 4 KiB) -> err=1, and a follow-up read of 0x8000_0000 shows no change.
   - Read 0x7FFF_FFFC -> err=1.
6. Reset mid-write: accept a write of 0xCAFEF00D to 0x8000_0020, assert rst during WAIT -> no rsp_valid. A later read of 0x8000_0020 returns the prior value.
